// File: rtl/mhd_pkg.sv
// rtl/mhd_pkg.sv - shared types and width helpers for the MHD stream monitor
package mhd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int hd_width(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int sum_width(input int width, input int cnt_w);
    return cnt_w + hd_width(width);
  endfunction

endpackage

// File: rtl/mhd_slice_popcount.sv
// rtl/mhd_slice_popcount.sv - combinational popcount of one SLICE-bit slice
module mhd_slice_popcount #(
  parameter int SLICE = 32,
  localparam int PC_W = $clog2(SLICE + 1)
) (
  input  logic [SLICE-1:0] din,
  output logic [PC_W-1:0]  cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < SLICE; i++) begin
      cnt = cnt + PC_W'(din[i]);
    end
  end

endmodule

// File: rtl/mhd_stream_monitor.sv
// rtl/mhd_stream_monitor.sv - Hamming-distance statistics over a stream of vector pairs
module mhd_stream_monitor
  import mhd_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int SLICE = 32,
  parameter int CNT_W = 16,
  localparam int HD_W  = hd_width(WIDTH),
  localparam int SUM_W = sum_width(WIDTH, CNT_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             busy,
  output logic             done,
  output logic [HD_W-1:0]  last_hd,
  output logic [SUM_W-1:0] hd_sum,
  output logic [HD_W-1:0]  hd_max,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int SLICES = WIDTH / SLICE;
  localparam int K_W    = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int PC_W   = $clog2(SLICE + 1);

  state_t           state;
  logic [WIDTH-1:0] diff_q;
  logic [K_W-1:0]   k;
  logic [HD_W-1:0]  acc;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] cnt;

  logic [SLICE-1:0] slice_bits;
  logic [PC_W-1:0]  pc;
  logic [HD_W-1:0]  acc_next;
  logic [HD_W-1:0]  max_next;
  logic [CNT_W-1:0] cnt_next;
  logic             last_slice;

  // One narrow popcount shared across all slices of the stored difference.
  assign slice_bits = diff_q[int'(k)*SLICE +: SLICE];

  mhd_slice_popcount #(.SLICE(SLICE)) u_popcount (
    .din (slice_bits),
    .cnt (pc)
  );

  assign acc_next   = acc + HD_W'(pc);
  assign max_next   = (acc_next > hd_max) ? acc_next : hd_max;
  assign cnt_next   = cnt + CNT_W'(1);
  assign last_slice = (k == K_W'(SLICES - 1));
  assign in_ready   = (state == LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      diff_q  <= '0;
      k       <= '0;
      acc     <= '0;
      num_q   <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      last_hd <= '0;
      hd_sum  <= '0;
      hd_max  <= '0;
      err_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            num_q   <= num_samples;
            cnt     <= '0;
            last_hd <= '0;
            hd_sum  <= '0;
            hd_max  <= '0;
            err_cnt <= '0;
            if (num_samples == '0) begin
              state <= DONE;
            end else begin
              state <= LOAD;
              busy  <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (in_valid) begin
            diff_q <= in_a ^ in_b;
            acc    <= '0;
            k      <= '0;
            state  <= COUNT;
          end
        end
        COUNT: begin
          acc <= acc_next;
          k   <= k + K_W'(1);
          // The final slice is folded in on the same edge the statistics update.
          if (last_slice) begin
            last_hd <= acc_next;
            hd_sum  <= hd_sum + SUM_W'(acc_next);
            hd_max  <= max_next;
            err_cnt <= err_cnt + CNT_W'(acc_next != '0);
            cnt     <= cnt_next;
            if (cnt_next == num_q) begin
              state <= DONE;
              busy  <= 1'b0;
            end else begin
              state <= LOAD;
            end
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mhd_stream_monitor.sv
// tb/tb_mhd_stream_monitor.sv - self-checking bench for mhd_stream_monitor
module tb_mhd_stream_monitor;

  localparam int SLICES = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [15:0]  num_samples;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_a;
  logic [127:0] in_b;
  logic         busy;
  logic         done;
  logic [7:0]   last_hd;
  logic [23:0]  hd_sum;
  logic [7:0]   hd_max;
  logic [15:0]  err_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  mhd_stream_monitor dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_samples (num_samples),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .busy        (busy),
    .done        (done),
    .last_hd     (last_hd),
    .hd_sum      (hd_sum),
    .hd_max      (hd_max),
    .err_cnt     (err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: a run is busy from start until its last sample is
  // counted; each accepted pair is counted for SLICES cycles, then folded in.
  bit m_busy, m_dstate, m_done;
  int m_cd, m_num, m_cnt, m_pend, m_last, m_sum, m_max, m_err;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_dstate = 0; m_done = 0; m_cd = 0; m_num = 0; m_cnt = 0;
      m_pend = 0; m_last = 0; m_sum = 0; m_max = 0; m_err = 0;
    end
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("in_ready", in_ready, m_busy && m_cd == 0);
    chk("last_hd", last_hd, m_last);
    chk("hd_sum", hd_sum, m_sum);
    chk("hd_max", hd_max, m_max);
    chk("err_cnt", err_cnt, m_err);
    if (rst_n) begin
      m_done = m_dstate;
      if (m_dstate) begin
        m_dstate = 0;
      end else if (!m_busy && start) begin
        m_num = num_samples; m_cnt = 0;
        m_last = 0; m_sum = 0; m_max = 0; m_err = 0;
        if (num_samples == 0) m_dstate = 1;
        else m_busy = 1;
      end else if (m_busy && m_cd > 0) begin
        if (m_cd == 1) begin
          m_last = m_pend;
          m_sum += m_pend;
          if (m_pend > m_max) m_max = m_pend;
          if (m_pend != 0) m_err++;
          m_cnt++;
          if (m_cnt == m_num) begin
            m_busy = 0;
            m_dstate = 1;
          end
        end
        m_cd--;
      end else if (m_busy && in_valid) begin
        m_pend = $countones(in_a ^ in_b);
        m_cd = SLICES;
      end
    end
  end

  task automatic run_start(input logic [15:0] n);
    @(posedge clk); #1;
    start = 1'b1;
    num_samples = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic push(input logic [127:0] a, input logic [127:0] b, input bit hold, output int hcyc);
    int guard;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    guard = 0;
    hcyc = -1;
    while (guard < 100) begin
      @(negedge clk);
      guard++;
      if (in_ready) begin
        @(posedge clk); #1;
        hcyc = cyc;
        break;
      end
    end
    if (hcyc < 0) chk("handshake_timeout", 0, 1);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] a, m;
    int lat, hc, hprev, dcount;

    rst_n = 1'b1;
    start = 1'b0;
    num_samples = '0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_hd_sum", hd_sum, 0);
    chk("reset_in_ready", in_ready, 0);

    // single sample, every bit different
    run_start(16'd1);
    push({128{1'b1}}, '0, 0, hc);
    wait_done(lat);
    chk("t1_latency", lat, 6);
    chk("t1_last_hd", last_hd, 128);
    chk("t1_hd_sum", hd_sum, 128);
    chk("t1_hd_max", hd_max, 128);
    chk("t1_err_cnt", err_cnt, 1);

    // empty run clears results and finishes without accepting data
    run_start(16'd0);
    wait_done(lat);
    chk("t0_latency", lat, 2);
    chk("t0_hd_sum", hd_sum, 0);
    chk("t0_hd_max", hd_max, 0);

    // three samples with distances 0, 5, 2
    run_start(16'd3);
    a = rnd128();
    push(a, a, 0, hc);
    m = '0; m[0] = 1; m[33] = 1; m[64] = 1; m[100] = 1; m[127] = 1;
    a = rnd128();
    push(a, a ^ m, 0, hc);
    m = '0; m[31] = 1; m[32] = 1;
    a = rnd128();
    push(a, a ^ m, 0, hc);
    wait_done(lat);
    chk("t3_hd_sum", hd_sum, 7);
    chk("t3_hd_max", hd_max, 5);
    chk("t3_err_cnt", err_cnt, 2);
    chk("t3_last_hd", last_hd, 2);

    // back-to-back, valid held high, only bit 127 differs
    run_start(16'd4);
    m = '0; m[127] = 1;
    hprev = -1;
    for (int i = 0; i < 4; i++) begin
      a = rnd128();
      push(a, a ^ m, (i < 3), hc);
      if (hprev >= 0) chk("bb_interval", hc - hprev, 5);
      hprev = hc;
    end
    wait_done(lat);
    chk("bb_hd_sum", hd_sum, 4);
    chk("bb_hd_max", hd_max, 1);
    chk("bb_err_cnt", err_cnt, 4);

    // start while busy is ignored
    run_start(16'd2);
    m = '0; m[1] = 1; m[40] = 1; m[90] = 1;
    a = rnd128();
    push(a, a ^ m, 0, hc);
    start = 1'b1;
    num_samples = 16'd5;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    m = '0; m[70] = 1;
    a = rnd128();
    push(a, a ^ m, 0, hc);
    wait_done(lat);
    chk("sb_done_latency", lat, 6);
    chk("sb_hd_sum", hd_sum, 4);
    chk("sb_hd_max", hd_max, 3);
    chk("sb_err_cnt", err_cnt, 2);
    chk("sb_last_hd", last_hd, 1);

    // reset during the third sample's count phase
    run_start(16'd5);
    m = '0; m[5] = 1; m[50] = 1; m[120] = 1;
    a = rnd128();
    push(a, a ^ m, 0, hc);
    m = '0; m[2] = 1; m[3] = 1; m[66] = 1; m[99] = 1;
    a = rnd128();
    push(a, a ^ m, 0, hc);
    m = '0; m[10] = 1; m[20] = 1; m[30] = 1; m[40] = 1; m[80] = 1; m[110] = 1;
    a = rnd128();
    push(a, a ^ m, 0, hc);
    @(negedge clk);
    chk("rst_pre_hd_sum", hd_sum, 7);
    chk("rst_pre_busy", busy, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_hd_sum", hd_sum, 0);
    chk("rst_hd_max", hd_max, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_last_hd", last_hd, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dcount = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("rst_no_done", dcount, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mhd_stream_monitor.md
# mhd_stream_monitor

Sequential error-statistics engine for Hamming-distance (MHD) miters. It accepts a programmed number of exact/approximate output-vector pairs over a valid/ready stream and computes each pair's Hamming distance. The 128-bit popcount is time-multiplexed over one narrow slice-popcount unit. Results are accumulated into sum, maximum and erroneous-sample count, so one monitor replaces a full-width combinational deviation tree during hardware-assisted error evaluation.

## Interface
Parameters:
- WIDTH, 128, compared vector width; must be a multiple of SLICE.
- SLICE, 32, bits popcounted per cycle.
- CNT_W, 16, width of sample counters.
- Derived: HD_W = $clog2(WIDTH+1) (8 at default); SUM_W = CNT_W + HD_W; SLICES = WIDTH/SLICE.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- num_samples  in  CNT_W  samples in the run; captured on accepted start.
- in_valid  in  1  pair available.
- in_ready  out  1  monitor can accept a pair.
- in_a  in  WIDTH  exact output vector.
- in_b  in  WIDTH  approximate output vector.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- last_hd  out  HD_W  Hamming distance of most recently finished sample.
- hd_sum  out  SUM_W  sum of Hamming distances in the run.
- hd_max  out  HD_W  maximum Hamming distance in the run.
- err_cnt  out  CNT_W  samples with nonzero distance.

## Operation
- States: IDLE, LOAD, COUNT, DONE.
- IDLE:
  - start=1 latches num_samples and clears hd_sum, hd_max, err_cnt, last_hd and the sample counter.
  - Goes to LOAD, or directly to DONE if num_samples==0.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready: diff_q <= in_a^in_b, acc <= 0, slice index k <= 0, then go to COUNT.
- COUNT:
  - Each cycle: acc += popcount(diff_q[k*SLICE +: SLICE]), k++.
  - After slice SLICES-1 (the same edge folds in the last slice):
    - last_hd <= final acc.
    - hd_sum += final acc.
    - hd_max <= max(hd_max, final acc).
    - err_cnt += (final acc != 0).
    - Sample counter increments.
    - Go to DONE if counter reaches num_samples, else back to LOAD.
- DONE: done=1 for exactly one cycle, then IDLE.
- Results hold until the next accepted start.
- start while busy is ignored. in_valid outside LOAD is not accepted; input stays stalled.
- hd_sum cannot overflow by construction (SUM_W sizing); no saturation logic.
- Reset mid-run aborts immediately. All state and outputs are cleared; the in-flight sample is discarded.

## Timing
- Reset values: in_ready=0, busy=0, done=0, last_hd=0, hd_sum=0, hd_max=0, err_cnt=0, state=IDLE.
- busy=1 from the cycle after start is accepted through the last COUNT cycle. busy is 0 in DONE.
- Handshake edge E: COUNT occupies the SLICES cycles after E. Statistics update at edge E+SLICES.
- in_ready is 0 during COUNT.
- Throughput: one sample per SLICES+1 cycles (5 at default). Per-sample latency: SLICES cycles.
- done is asserted the cycle after the final statistics update. Outputs are valid and stable when done=1.
- num_samples==0: done pulses 2 cycles after the start edge, with all results 0.
- All outputs are registered; no combinational path from inputs to outputs except none (in_ready is state-decoded).

## Structure
- Shared package mhd_pkg holds:
  - The state enum (IDLE/LOAD/COUNT/DONE).
  - Functions computing HD_W and SUM_W from WIDTH and CNT_W.
- Sub-module mhd_slice_popcount: combinational SLICE-bit popcount, output $clog2(SLICE+1) bits. It is instantiated once and fed by a mux on k.
- Top: FSM, diff register, slice index, accumulator, statistics registers.

## Test plan
- Reset mid-COUNT (rst_n low 1 cycle during the 3rd sample) -> all outputs 0 next cycle, state IDLE, no done pulse.
- num_samples=1, a=all-ones, b=0 -> in_ready drops for 4 cycles; done pulse; last_hd=128, hd_sum=128, hd_max=128, err_cnt=1.
- num_samples=3, pairs with HD 0, 5, 2 -> hd_sum=7, hd_max=5, err_cnt=2, last_hd=2.
- num_samples=0 -> done 2 cycles after start; all results 0; in_ready never asserted.
- Back-to-back in_valid held high, num_samples=4, each pair differs only in bit 127 (last slice) -> accepts every 5 cycles, hd_sum=4, hd_max=1.
- start pulsed while busy with different num_samples -> ignored; run completes with the original count.
